// File: rtl/sid_audio_pkg.sv
// Shared audio-path constants and types for the SID core and its I2S serializer.
package sid_audio_pkg;

  localparam int unsigned SID_SAMPLE_W    = 16;
  localparam int unsigned SLOTS_PER_FRAME = 32;
  localparam int unsigned SLOT_W          = $clog2(SLOTS_PER_FRAME);

  // Slot entered on the fall event that loads a new frame
  localparam logic [SLOT_W-1:0] SLOT_LOAD        = SLOT_W'(1);
  // First slot of the right channel (word select high)
  localparam logic [SLOT_W-1:0] SLOT_RIGHT_START = SLOT_W'(16);
  // Slot held in reset so the first fall event enters slot 0
  localparam logic [SLOT_W-1:0] SLOT_RESET       = SLOT_W'(SLOTS_PER_FRAME - 1);

  // Signed mixed/filtered SID output sample
  typedef logic signed [SID_SAMPLE_W-1:0] sid_sample_t;

endpackage

// File: rtl/sid_i2s_clkgen.sv
// Bit-clock divider: toggles bclk every CLK_DIV clk cycles and flags the
// clk edge on which bclk falls so the serializer can update in lockstep.
module sid_i2s_clkgen #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic clk,
  input  logic rstN,
  output logic bclk,
  output logic fall_c
);

  localparam int unsigned        CNT_W    = 8;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             terminal_c;

  assign terminal_c = (cnt == CNT_LAST);
  // High on the edge where bclk goes 1->0
  assign fall_c     = terminal_c & bclk;

  // Half-period counter; bclk toggles at terminal count
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt  <= '0;
      bclk <= 1'b0;
    end else if (terminal_c) begin
      cnt  <= '0;
      bclk <= ~bclk;
    end else begin
      cnt  <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sid_i2s_tx.sv
// Philips I2S transmitter for the SID output: mono sample duplicated into
// left and right slots, 32 BCLK per frame, sample repeat on underrun.
module sid_i2s_tx
  import sid_audio_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 8,
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic [SAMPLE_W-1:0] iSample,
  input  logic                iValid,
  input  logic                iMute,
  output logic                oBclk,
  output logic                oLrclk,
  output logic                oSdata,
  output logic                oFrameStart,
  output logic                oUnderrun
);

  localparam int unsigned BIT_W = $clog2(SAMPLE_W);

  logic                fall_c;
  logic [SLOT_W-1:0]   slot_q;
  logic [SLOT_W-1:0]   slot_d;
  logic [SLOT_W-1:0]   neg_slot;
  logic                load_c;
  logic                lrclk_d;
  logic                sdata_d;
  logic [SAMPLE_W-1:0] holding;
  logic [SAMPLE_W-1:0] frame;
  logic [SAMPLE_W-1:0] frame_d;
  logic                fresh;

  // Bit clock and fall-event strobe
  sid_i2s_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk    (clk),
    .rstN   (rstN),
    .bclk   (oBclk),
    .fall_c (fall_c)
  );

  // Next slot, frame load and serial bit selection on each fall event
  always_comb begin
    slot_d   = slot_q;
    load_c   = 1'b0;
    frame_d  = frame;
    lrclk_d  = oLrclk;
    sdata_d  = oSdata;
    neg_slot = '0;
    if (fall_c) begin
      slot_d  = slot_q + SLOT_W'(1);
      load_c  = (slot_d == SLOT_LOAD);
      if (load_c) begin
        frame_d = iMute ? '0 : holding;
      end
      lrclk_d  = (slot_d >= SLOT_RIGHT_START);
      // (16 - slot) mod 16: slot 0 -> bit 0 (one-bit delay), slot 1 -> MSB,
      // slot 17 -> bit 15 of the right copy
      neg_slot = SLOT_W'(0) - slot_d;
      sdata_d  = frame_d[neg_slot[BIT_W-1:0]];
    end
  end

  // Slot counter, frame register and registered serial outputs
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      slot_q      <= SLOT_RESET;
      frame       <= '0;
      oLrclk      <= 1'b1;
      oSdata      <= 1'b0;
      oFrameStart <= 1'b0;
      oUnderrun   <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      frame       <= frame_d;
      oLrclk      <= lrclk_d;
      oSdata      <= sdata_d;
      oFrameStart <= load_c;
      oUnderrun   <= load_c & ~fresh;
    end
  end

  // Holding register: newest sample wins; fresh survives a coincident load
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      holding <= '0;
      fresh   <= 1'b0;
    end else if (iValid) begin
      holding <= iSample;
      fresh   <= 1'b1;
    end else if (load_c) begin
      fresh   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sid_i2s_tx.sv
// Bench for sid_i2s_tx: directed stimulus pushes expected frames into a
// queue; a monitor reassembles each serialized frame and compares.
module tb_sid_i2s_tx;

  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned FRAME_CLKS = 2 * CLK_DIV * 32;

  typedef struct packed {
    logic [15:0] d;
    logic        ur;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [15:0] iSample = 16'h0;
  logic        iValid = 1'b0;
  logic        iMute = 1'b0;
  logic        oBclk, oLrclk, oSdata, oFrameStart, oUnderrun;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  sid_i2s_tx #(
    .CLK_DIV  (CLK_DIV),
    .SAMPLE_W (16)
  ) dut (
    .clk         (clk),
    .rstN        (rstN),
    .iSample     (iSample),
    .iValid      (iValid),
    .iMute       (iMute),
    .oBclk       (oBclk),
    .oLrclk      (oLrclk),
    .oSdata      (oSdata),
    .oFrameStart (oFrameStart),
    .oUnderrun   (oUnderrun)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [15:0] d, input logic ur);
    exp_t e;
    e.d  = d;
    e.ur = ur;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bclk"},  32'(oBclk),       32'd0);
    chk({tag, "_lrclk"}, 32'(oLrclk),      32'd1);
    chk({tag, "_sdata"}, 32'(oSdata),      32'd0);
    chk({tag, "_fs"},    32'(oFrameStart), 32'd0);
    chk({tag, "_ur"},    32'(oUnderrun),   32'd0);
  endtask

  // Called just after rstN rises between edges; ends on the first load negedge
  task automatic check_release(input string tag);
    repeat (3) @(negedge clk);
    chk({tag, "_bclk_high"},  32'(oBclk),  32'd1);
    chk({tag, "_lr_hold"},    32'(oLrclk), 32'd1);
    @(negedge clk);
    chk({tag, "_lr_fall"},    32'(oLrclk), 32'd0);
    chk({tag, "_bclk_fall"},  32'(oBclk),  32'd0);
    repeat (3) @(negedge clk);
    chk({tag, "_fs_early"},   32'(oFrameStart), 32'd0);
    @(negedge clk);
    chk({tag, "_fs_first"},   32'(oFrameStart), 32'd1);
    chk({tag, "_ur_first"},   32'(oUnderrun),   32'd1);
  endtask

  task automatic wait_fs(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < int'(FRAME_CLKS) + 16 && !seen; i++) begin
      @(negedge clk);
      seen = oFrameStart;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s actual=no_frame_start required=frame_start", name);
    end
  endtask

  task automatic pulse(input logic [15:0] v);
    iSample = v;
    iValid  = 1'b1;
    @(negedge clk);
    iValid  = 1'b0;
  endtask

  // Monitor: reassemble each frame from slot 1 through the next slot 0
  initial begin
    bit          prev_bclk = 1'b0;
    bit          synced = 1'b0;
    bit          fs_known = 1'b0;
    bit          ur_seen = 1'b0;
    bit          fall;
    logic [4:0]  slot = 5'd0;
    logic [31:0] sh = '0;
    logic [31:0] lr = '0;
    int          clk_cnt = 0;
    int          last_fs = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rstN) begin
        prev_bclk = 1'b0;
        synced    = 1'b0;
        fs_known  = 1'b0;
      end else begin
        clk_cnt++;
        fall      = prev_bclk && !oBclk;
        prev_bclk = oBclk;
        if (oUnderrun || oFrameStart)
          chk("ur_only_with_fs", 32'(oUnderrun && !oFrameStart), 32'd0);
        if (oFrameStart) begin
          chk("fs_on_fall", 32'(fall), 32'd1);
          if (fs_known) chk("fs_period", 32'(clk_cnt - last_fs), 32'(FRAME_CLKS));
          if (synced) chk("fs_after_slot0", 32'(slot), 32'd0);
          last_fs  = clk_cnt;
          fs_known = 1'b1;
          synced   = 1'b1;
          slot     = 5'd1;
          ur_seen  = oUnderrun;
          sh       = {31'd0, oSdata};
          lr       = '0;
          lr[1]    = oLrclk;
        end else if (fall && synced) begin
          slot     = slot + 5'd1;
          sh       = {sh[30:0], oSdata};
          lr[slot] = oLrclk;
          if (slot == 5'd0) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_frame", sh, 32'hxxxx_xxxx);
            end else begin
              e = exp_q.pop_front();
              chk("frame_data",     sh,           {e.d, e.d});
              chk("frame_underrun", 32'(ur_seen), 32'(e.ur));
              chk("frame_lrclk",    lr,           32'hFFFF_0000);
            end
          end
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    exp_q.push_back(mk(16'h0000, 1'b1));
    #2 rstN = 1'b1;
    check_release("init");

    // Single sample with both end bits set
    repeat (20) @(negedge clk);
    pulse(16'h8001);
    exp_q.push_back(mk(16'h8001, 1'b0));
    wait_fs("fs1");

    // iValid every 8 clk; pulse 16 lands exactly on the next load
    exp_q.push_back(mk(16'h100F, 1'b0));
    exp_q.push_back(mk(16'h1010, 1'b0));
    repeat (7) @(negedge clk);
    for (int k = 1; k <= 16; k++) begin
      pulse(16'h1000 + 16'(k));
      if (k < 16) repeat (7) @(negedge clk);
    end
    chk("fs_cadence", 32'(oFrameStart), 32'd1);
    repeat (40) @(negedge clk);
    iSample = 16'hDEAD;
    wait_fs("fs3");

    // One fresh sample, then three starved frames repeating it
    repeat (30) @(negedge clk);
    pulse(16'h1234);
    iSample = 16'hBEEF;
    exp_q.push_back(mk(16'h1234, 1'b0));
    wait_fs("fs4");
    for (int r = 0; r < 3; r++) begin
      exp_q.push_back(mk(16'h1234, 1'b1));
      repeat (50) @(negedge clk);
      iSample = 16'h5A5A ^ 16'(r);
      wait_fs("fs_starved");
    end

    // Mute at load, then unmute restores the held sample
    repeat (10) @(negedge clk);
    pulse(16'h7FFF);
    repeat (10) @(negedge clk);
    iMute = 1'b1;
    exp_q.push_back(mk(16'h0000, 1'b0));
    wait_fs("fs_mute");
    repeat (2) @(negedge clk);
    iMute = 1'b0;
    exp_q.push_back(mk(16'h7FFF, 1'b1));
    wait_fs("fs_unmute");

    // Reset asserted in slot 20 of a 0x7FFF frame
    repeat (76) @(negedge clk);
    #2 rstN = 1'b0;
    #1 chk_reset_vals("midreset");
    exp_q.delete();
    exp_q.push_back(mk(16'h0000, 1'b1));
    repeat (3) @(negedge clk);
    #2 rstN = 1'b1;
    check_release("rerelease");

    repeat (40) @(negedge clk);
    pulse(16'hA5C3);
    exp_q.push_back(mk(16'hA5C3, 1'b0));
    wait_fs("fs_after_reset");

    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
